instruction_fetch: RTL and testbench

//  Fetch stage in front of the instruction decoder. Issues 32-bit instruction reads on the

---
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/instruction_fetch.sv | 139 +++++++++++++
 tb/tb_instruction_fetch.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction read bus, redirect request and decoder-side handshake.
`default_nettype none

interface instruction_fetch_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_pc;

  modport master (
    output mem_valid, mem_address, fetch_valid, fetch_data, fetch_pc,
    input  mem_ready, mem_rdata, redirect_valid, redirect_pc, fetch_ready
  );

  modport slave (
    input  mem_valid, mem_address, fetch_valid, fetch_data, fetch_pc,
    output mem_ready, mem_rdata, redirect_valid, redirect_pc, fetch_ready
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one-outstanding-read bus master feeding a small {pc, word} FIFO.
`default_nettype none

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_fetch_if.master   bus
);

  localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic [31:0]      stale_addr;
  logic [31:0]      stale_addr_next;
  logic             push;
  logic             pop;
  logic             transfer;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign transfer = bus.mem_valid && bus.mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      stale_addr <= stale_addr_next;
    end
  end

  // Redirect outranks everything; a request already on the bus must still be completed,
  // so it is parked in DROP until its response arrives and can be thrown away.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    stale_addr_next  = stale_addr;
    push             = 1'b0;
    bus.mem_valid    = 1'b0;
    bus.mem_address  = pc;

    case (state)
      FETCH: begin
        bus.mem_valid   = !reset && (count < FULL_COUNT);
        bus.mem_address = pc;
      end
      DROP: begin
        bus.mem_valid   = !reset;
        bus.mem_address = stale_addr;
      end
      default: begin
        bus.mem_valid   = 1'b0;
        bus.mem_address = pc;
      end
    endcase

    if (bus.redirect_valid) begin
      pc_next = bus.redirect_pc & 32'hFFFF_FFFC;
      if (transfer) begin
        state_next = FETCH;
      end else if (bus.mem_valid) begin
        state_next      = DROP;
        stale_addr_next = bus.mem_address;
      end else begin
        state_next = FETCH;
      end
    end else if (state == FETCH) begin
      if (transfer) begin
        push    = 1'b1;
        pc_next = pc + 32'd4;
      end
    end else if (bus.mem_ready) begin
      state_next = FETCH;
    end
  end

  assign bus.fetch_valid = (count != '0);
  assign bus.fetch_data  = data_mem[rd_ptr];
  assign bus.fetch_pc    = pc_mem[rd_ptr];
  assign pop             = bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= pc;
        data_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: queue of expected {pc, word} checked by a decode-side monitor.
`default_nettype none

module tb_instruction_fetch;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word derived from its address so dropped/misaddressed reads are visible.
  assign bus.mem_rdata = bus.mem_address + 32'h1000_0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back({pc, data});
  endtask

  always @(negedge clk) begin
    if (!reset && bus.fetch_valid && bus.fetch_ready && !bus.redirect_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fetch_unexpected: got pc=%h data=%h expected nothing", bus.fetch_pc, bus.fetch_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({bus.fetch_pc, bus.fetch_data} !== e) begin
          bad++;
          $display("FAIL fetch_word: got pc=%h data=%h expected pc=%h data=%h",
                   bus.fetch_pc, bus.fetch_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    total              = 0;
    bad                = 0;
    reset              = 1'b1;
    bus.mem_ready      = 1'b1;
    bus.fetch_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    tick();
    #2;
    check("rst_mem_valid",   {31'b0, bus.mem_valid},   32'h0);
    check("rst_mem_address", bus.mem_address,          32'h0000_0100);
    check("rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    check("rst_fetch_data",  bus.fetch_data,           32'h0);
    check("rst_fetch_pc",    bus.fetch_pc,             32'h0);

    // Streaming from RESET_PC with everything ready
    expect_word(32'h0000_0100, 32'h1000_0100);
    expect_word(32'h0000_0104, 32'h1000_0104);
    expect_word(32'h0000_0108, 32'h1000_0108);
    tick(); reset = 1'b0;
    #2; check("t1_mem_valid", {31'b0, bus.mem_valid}, 32'h1);
    check("t1_addr0", bus.mem_address, 32'h0000_0100);
    tick(); #2; check("t1_addr1", bus.mem_address, 32'h0000_0104);
    tick(); #2; check("t1_addr2", bus.mem_address, 32'h0000_0108);
    tick(); bus.mem_ready = 1'b0;
    #2; check("t1_addr3", bus.mem_address, 32'h0000_010C);

    // Decoder stalled: FIFO fills to DEPTH then requests stop
    expect_word(32'h0000_010C, 32'h1000_010C);
    expect_word(32'h0000_0110, 32'h1000_0110);
    tick(); bus.mem_ready = 1'b1; bus.fetch_ready = 1'b0;
    tick();
    tick(); #2;
    check("t2_full_mem_valid", {31'b0, bus.mem_valid},   32'h0);
    check("t2_fetch_valid",    {31'b0, bus.fetch_valid}, 32'h1);
    check("t2_head_pc",        bus.fetch_pc,             32'h0000_010C);
    check("t2_head_data",      bus.fetch_data,           32'h1000_010C);
    tick(); bus.fetch_ready = 1'b1;
    #2; check("t2_still_full", {31'b0, bus.mem_valid}, 32'h0);
    tick(); #2;
    check("t2_resume_valid", {31'b0, bus.mem_valid}, 32'h1);
    check("t2_resume_addr",  bus.mem_address,        32'h0000_0114);

    // Redirect coinciding with a transfer and a pop
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    #2; check("t4_buffered", {31'b0, bus.fetch_valid}, 32'h1);
    tick(); bus.redirect_valid = 1'b0; bus.mem_ready = 1'b0;
    #2;
    check("t4_flushed",    {31'b0, bus.fetch_valid}, 32'h0);
    check("t4_new_addr",   bus.mem_address,          32'h0000_0200);
    check("t4_new_valid",  {31'b0, bus.mem_valid},   32'h1);

    // Redirect while a request is stalled: stale response must be dropped
    expect_word(32'h0000_0400, 32'h1000_0400);
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0400;
    tick(); bus.redirect_valid = 1'b0;
    #2;
    check("t3_hold_valid", {31'b0, bus.mem_valid}, 32'h1);
    check("t3_hold_addr0", bus.mem_address,        32'h0000_0200);
    tick(); bus.mem_ready = 1'b1;
    #2; check("t3_hold_addr1", bus.mem_address, 32'h0000_0200);
    tick(); #2;
    check("t3_target_addr", bus.mem_address,          32'h0000_0400);
    check("t3_no_stale",    {31'b0, bus.fetch_valid}, 32'h0);
    tick();

    // Misaligned redirect target and PC wrap
    expect_word(32'hFFFF_FFFC, 32'h0FFF_FFFC);
    expect_word(32'h0000_0000, 32'h1000_0000);
    tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
    tick(); bus.redirect_valid = 1'b0;
    #2; check("t5_aligned", bus.mem_address, 32'hFFFF_FFFC);
    tick(); #2; check("t5_wrap", bus.mem_address, 32'h0000_0000);
    tick(); bus.mem_ready = 1'b0;
    #2; check("t5_after_wrap", bus.mem_address, 32'h0000_0004);

    // Reset while a request is pending
    expect_word(32'h0000_0100, 32'h1000_0100);
    tick(); #2;
    check("t6_pending", {31'b0, bus.mem_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("t6_rst_mem_valid",   {31'b0, bus.mem_valid},   32'h0);
    check("t6_rst_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
    check("t6_rst_addr",        bus.mem_address,          32'h0000_0100);
    tick(); reset = 1'b0; bus.mem_ready = 1'b1;
    #2; check("t6_restart_addr", bus.mem_address, 32'h0000_0100);
    tick(); bus.mem_ready = 1'b0;
    repeat (3) tick();

    check("drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
